// File: rtl/peripheral_bus_master_pkg.sv
// Shared types and constants for the peripheral bus initiator.
package peripheral_bus_master_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond
  } pbm_state_e;

  localparam int unsigned PbAddrWidth  = 24;
  localparam logic [31:0] UnmappedRead = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts busy cycles of one access; flags the last permitted cycle.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMEOUT_WIDTH  = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [TIMEOUT_WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  // High while sampling the final allowed busy cycle of the access.
  assign tc_o = (count_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/peripheral_bus_master.sv
// Wishbone classic slave to peripheral-bus initiator bridge with access timeout.
module peripheral_bus_master
  import peripheral_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = PbAddrWidth,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMEOUT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [31:0]           wb_dat_o,
  output logic                  peripheralBus_we,
  output logic                  peripheralBus_oe,
  input  logic                  peripheralBus_busy,
  output logic [ADDR_WIDTH-1:0] peripheralBus_address,
  output logic [3:0]            peripheralBus_byteSelect,
  output logic [31:0]           peripheralBus_dataWrite,
  input  logic [31:0]           peripheralBus_dataRead,
  input  logic                  requestOutput,
  output logic [7:0]            timeoutCount
);

  pbm_state_e            state_q;
  logic                  ack_q, err_q;
  logic [31:0]           rdata_q;
  logic                  we_q, oe_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [7:0]            tcount_q;

  logic accept, tmo_clear, tmo_enable, tmo_tc;

  always_comb begin
    accept     = (state_q == StIdle) && wb_cyc_i && wb_stb_i;
    tmo_clear  = accept;
    tmo_enable = (state_q == StAccess) && wb_cyc_i && peripheralBus_busy;
  end

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .tc_o     (tmo_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      tcount_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StAccess;
            addr_q  <= wb_adr_i;
            sel_q   <= wb_sel_i;
            wdata_q <= wb_dat_i;
            we_q    <= wb_we_i;
            oe_q    <= !wb_we_i;
          end
        end
        StAccess: begin
          if (!wb_cyc_i || !peripheralBus_busy || tmo_tc) begin
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
          end
          if (!wb_cyc_i) begin
            // Initiator abandoned the cycle: no response is owed.
            state_q <= StIdle;
          end else if (!peripheralBus_busy) begin
            state_q <= StRespond;
            ack_q   <= 1'b1;
            rdata_q <= (oe_q && requestOutput) ? peripheralBus_dataRead : UnmappedRead;
          end else if (tmo_tc) begin
            state_q <= StRespond;
            err_q   <= 1'b1;
            rdata_q <= UnmappedRead;
            if (tcount_q != 8'hFF) begin
              tcount_q <= tcount_q + 8'd1;
            end
          end
        end
        StRespond: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign wb_ack_o                 = ack_q;
  assign wb_err_o                 = err_q;
  assign wb_dat_o                 = rdata_q;
  assign peripheralBus_we         = we_q;
  assign peripheralBus_oe         = oe_q;
  assign peripheralBus_address    = addr_q;
  assign peripheralBus_byteSelect = sel_q;
  assign peripheralBus_dataWrite  = wdata_q;
  assign timeoutCount             = tcount_q;

endmodule
